// File: rtl/iob_mem_responder.sv
// IOb responder serving one request at a time from a byte-writable word RAM.
// Latency: completion at the accept edge plus WAIT_CYCLES; rvalid follows one cycle later.
// Backpressure: ready drops for WAIT_CYCLES cycles after each accept; cke_i low freezes everything.
module iob_mem_responder #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cke_i,
    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  iob_ready_o
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int DEPTH  = 2 ** IDX_W;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [0:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic              cmp_vld;
    logic [IDX_W-1:0]  cmp_idx;
    logic [DATA_W-1:0] cmp_wdata;
    logic [STRB_W-1:0] cmp_wstrb;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-offset bits carry no information for a word-wide memory.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^iob_addr_i[1:0];

    assign iob_ready_o  = (state_q == ST_IDLE);
    assign iob_rvalid_o = rvalid_q;
    assign iob_rdata_o  = rdata_q;

    assign accept = iob_avalid_i & iob_ready_o & cke_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        cmp_vld   = 1'b0;
        cmp_idx   = idx_q;
        cmp_wdata = wdata_q;
        cmp_wstrb = wstrb_q;

        if (cke_i) begin
            rvalid_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        idx_d   = iob_addr_i[ADDR_W-1:2];
                        wdata_d = iob_wdata_i;
                        wstrb_d = iob_wstrb_i;
                        if (WAIT_CYCLES == 0) begin
                            // Zero-wait requests complete straight from the bus.
                            cmp_vld   = 1'b1;
                            cmp_idx   = iob_addr_i[ADDR_W-1:2];
                            cmp_wdata = iob_wdata_i;
                            cmp_wstrb = iob_wstrb_i;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = WAIT_LOAD;
                        end
                    end
                end
                default: begin
                    if (cnt_q == 4'd0) begin
                        cmp_vld = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            endcase

            if (cmp_vld && (cmp_wstrb == '0)) begin
                rvalid_d = 1'b1;
                rdata_d  = mem[cmp_idx];
            end
        end
    end

    // Reset also suppresses a completion that lands on the reset edge.
    assign mem_we = cmp_vld & (|cmp_wstrb) & rst_n_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (cmp_wstrb[b]) begin
                    mem[cmp_idx][8*b +: 8] <= cmp_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_iob_mem_responder.sv
// Directed bench for iob_mem_responder: three instances with 0, 3 and 2 wait states
// share the request bus; each has its own avalid so only one is driven at a time.
module tb_iob_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cke;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        av_a, av_b, av_c;
    logic        rv_a, rv_b, rv_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic [31:0] rd_a, rd_b, rd_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iob_mem_responder #(.ADDR_W(12), .DATA_W(32), .WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .iob_avalid_i(av_a),
        .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_rvalid_o(rv_a), .iob_rdata_o(rd_a), .iob_ready_o(rdy_a)
    );

    iob_mem_responder #(.ADDR_W(12), .DATA_W(32), .WAIT_CYCLES(3)) u_w3 (
        .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .iob_avalid_i(av_b),
        .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_rvalid_o(rv_b), .iob_rdata_o(rd_b), .iob_ready_o(rdy_b)
    );

    iob_mem_responder #(.ADDR_W(12), .DATA_W(32), .WAIT_CYCLES(2)) u_w2 (
        .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .iob_avalid_i(av_c),
        .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_rvalid_o(rv_c), .iob_rdata_o(rd_c), .iob_ready_o(rdy_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_d;

        rst_n = 1'b0; cke = 1'b1;
        av_a = 1'b0; av_b = 1'b0; av_c = 1'b0;
        addr = '0; wdata = '0; wstrb = '0;
        repeat (2) step();
        rst_n = 1'b1;
        chk("rst_rdy_a", 32'(rdy_a), 32'd1);
        chk("rst_rv_a", 32'(rv_a), 32'd0);
        chk("rst_rd_a", rd_a, 32'h0);
        chk("rst_rdy_b", 32'(rdy_b), 32'd1);
        chk("rst_rv_c", 32'(rv_c), 32'd0);

        // Zero-wait write then read of the same word.
        av_a = 1'b1; addr = 12'h010; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        step();
        chk("w0_wr_rdy", 32'(rdy_a), 32'd1);
        chk("w0_wr_norv", 32'(rv_a), 32'd0);
        wstrb = 4'h0; wdata = 32'h0;
        step();
        chk("w0_rd_rv", 32'(rv_a), 32'd1);
        chk("w0_rd_data", rd_a, 32'hDEADBEEF);
        chk("w0_rd_rdy", 32'(rdy_a), 32'd1);
        av_a = 1'b0;
        step();
        chk("w0_rv_pulse", 32'(rv_a), 32'd0);
        chk("w0_rd_hold", rd_a, 32'hDEADBEEF);

        // Byte lanes, address alias, rdata unchanged by writes.
        av_a = 1'b1; addr = 12'h020; wdata = 32'h11223344; wstrb = 4'hF;
        step();
        wdata = 32'hAABBCCDD; wstrb = 4'h5;
        step();
        addr = 12'h023; wstrb = 4'h0;
        step();
        chk("lane_rv", 32'(rv_a), 32'd1);
        chk("lane_data", rd_a, 32'h11BB33DD);
        addr = 12'h030; wdata = 32'h0; wstrb = 4'hF;
        step();
        chk("wr_no_rv", 32'(rv_a), 32'd0);
        chk("wr_keeps_rd", rd_a, 32'h11BB33DD);
        av_a = 1'b0;

        // Three wait states, read held during the write's wait window.
        av_b = 1'b1; addr = 12'h050; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        step();
        wstrb = 4'h0; wdata = 32'h0;
        chk("w3_rdy_t1", 32'(rdy_b), 32'd0);
        step();
        chk("w3_rdy_t2", 32'(rdy_b), 32'd0);
        step();
        chk("w3_rdy_t3", 32'(rdy_b), 32'd0);
        chk("w3_norv_t3", 32'(rv_b), 32'd0);
        step();
        chk("w3_rdy_t4", 32'(rdy_b), 32'd1);
        chk("w3_wr_norv", 32'(rv_b), 32'd0);
        step();
        av_b = 1'b0;
        chk("w3_rd_rdy_t1", 32'(rdy_b), 32'd0);
        chk("w3_rd_rv_t1", 32'(rv_b), 32'd0);
        step();
        chk("w3_rd_rv_t2", 32'(rv_b), 32'd0);
        step();
        chk("w3_rd_rdy_t3", 32'(rdy_b), 32'd0);
        chk("w3_rd_rv_t3", 32'(rv_b), 32'd0);
        step();
        chk("w3_rd_rdy_t4", 32'(rdy_b), 32'd1);
        chk("w3_rd_rv_t4", 32'(rv_b), 32'd1);
        chk("w3_rd_data", rd_b, 32'hCAFEF00D);
        step();
        chk("w3_rv_drop", 32'(rv_b), 32'd0);

        // Reset while a write is waiting: the write must be dropped.
        av_b = 1'b1; addr = 12'h040; wdata = 32'h0; wstrb = 4'hF;
        step();
        av_b = 1'b0;
        repeat (3) step();
        chk("rst_pre_rdy", 32'(rdy_b), 32'd1);
        av_b = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        step();
        av_b = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_rdy", 32'(rdy_b), 32'd1);
        chk("midrst_rv", 32'(rv_b), 32'd0);
        chk("midrst_rd", rd_b, 32'h0);
        repeat (3) step();
        chk("midrst_no_rv", 32'(rv_b), 32'd0);
        av_b = 1'b1; wstrb = 4'h0; wdata = 32'h0;
        step();
        av_b = 1'b0;
        repeat (3) step();
        chk("midrst_rd_rv", 32'(rv_b), 32'd1);
        chk("midrst_rd_data", rd_b, 32'h0);

        // Two wait states with a five-cycle clock-enable stall.
        av_c = 1'b1; addr = 12'h060; wdata = 32'h5A5A1234; wstrb = 4'hF;
        step();
        av_c = 1'b0;
        repeat (2) step();
        chk("cke_pre_rdy", 32'(rdy_c), 32'd1);
        av_c = 1'b1; wstrb = 4'h0; wdata = 32'h0;
        step();
        av_c = 1'b0; cke = 1'b0;
        chk("cke_rdy_t1", 32'(rdy_c), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("cke_stall_rdy", 32'(rdy_c), 32'd0);
            chk("cke_stall_rv", 32'(rv_c), 32'd0);
        end
        cke = 1'b1;
        step();
        chk("cke_t7_rdy", 32'(rdy_c), 32'd0);
        chk("cke_t7_rv", 32'(rv_c), 32'd0);
        step();
        chk("cke_t8_rdy", 32'(rdy_c), 32'd1);
        chk("cke_t8_rv", 32'(rv_c), 32'd1);
        chk("cke_t8_data", rd_c, 32'h5A5A1234);
        cke = 1'b0;
        step();
        chk("cke_rv_frozen", 32'(rv_c), 32'd1);
        cke = 1'b1;
        step();
        chk("cke_rv_drop", 32'(rv_c), 32'd0);

        // Zero-wait full-throughput writes then 16 back-to-back reads.
        av_a = 1'b1; wstrb = 4'hF;
        for (int i = 0; i < 16; i++) begin
            addr  = 12'(12'h100 + 4 * i);
            wdata = 32'h1000_0000 + 32'h0001_0111 * 32'(i);
            step();
            chk("tp_wr_rdy", 32'(rdy_a), 32'd1);
        end
        wstrb = 4'h0; wdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            addr = 12'(12'h100 + 4 * i);
            step();
            exp_d = 32'h1000_0000 + 32'h0001_0111 * 32'(i);
            chk("tp_rv", 32'(rv_a), 32'd1);
            chk("tp_data", rd_a, exp_d);
        end
        av_a = 1'b0;
        step();
        chk("tp_rv_end", 32'(rv_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_mem_responder.md
Name: iob_mem_responder

Overview:
- Responder (slave) end of the IOb native bus driven by the CPU wrapper's ibus/dbus.
- Accepts one request at a time and serves it from an internal byte-writable word memory.
- Inserts a parameterised number of wait states by lowering ready.
- Used as boot/scratch RAM and as a bus model for exercising initiator back-pressure handling.

Parameters:
- ADDR_W, 12, byte address width; memory depth is 2**(ADDR_W-2) words.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).
- WAIT_CYCLES, 0, cycles ready is held low after each accepted request; legal range 0..15.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- cke_i  in  1  clock enable; when low, all state holds.
- iob_avalid_i  in  1  request valid.
- iob_addr_i  in  ADDR_W  byte address; bits [1:0] ignored.
- iob_wdata_i  in  DATA_W  write data.
- iob_wstrb_i  in  DATA_W/8  byte write strobes; nonzero = write, zero = read.
- iob_rvalid_o  out  1  one-cycle pulse; read data valid.
- iob_rdata_o  out  DATA_W  read data.
- iob_ready_o  out  1  responder can accept a request this cycle.

Behaviour:
- Reset: one clock is synchronous and active-low. Sampled rst_n_i=0 at a rising edge gives, from the next cycle:
  - iob_ready_o=1, iob_rvalid_o=0, iob_rdata_o=0, wait counter=0, FSM=IDLE.
  - Memory contents are not reset.
- Accept: a request is accepted at edge T when iob_avalid_i & iob_ready_o & cke_i.
  - addr word index (addr[ADDR_W-1:2]), wdata, wstrb and type (read/write) are latched at T.
  - The initiator need not hold the request after acceptance.
- FSM IDLE (ready=1):
  - On accept with WAIT_CYCLES=0, stay in IDLE and complete at edge T: the write commits, or read data is registered.
  - On accept with WAIT_CYCLES>0, go to WAIT and load the counter with WAIT_CYCLES-1.
- FSM WAIT (ready=0):
  - Decrement the counter each enabled cycle.
  - When the counter is 0, complete the latched request on that edge and return to IDLE.
  - Requests presented during WAIT are ignored (not accepted).
- Timing, for acceptance at edge T:
  - ready is low in cycles T+1 .. T+WAIT_CYCLES and high again at T+WAIT_CYCLES+1.
  - Read: iob_rvalid_o=1 for exactly cycle T+WAIT_CYCLES+1, with iob_rdata_o = word contents at completion.
  - Write: bytes whose strobe is set are updated at the completion edge and are visible to any later read. No rvalid is produced for writes.
- Back-to-back with WAIT_CYCLES=0: one request accepted per cycle, full throughput.
  - A read accepted at T+1 after a write accepted at T to the same word returns the new data (write-before-read ordering).
- iob_rdata_o holds its last read value between reads. It is not changed by writes.
- Reset mid-operation: a pending WAIT request is dropped.
  - A pending write is not committed; a pending read gives no rvalid.
- cke_i=0: counter, FSM, rvalid and rdata freeze; no acceptance and no memory write.
  - An rvalid that is high stays high until the next enabled cycle, then drops.
- wstrb=4'b0000 is always a read. Partial strobes (e.g. 4'b0110) update only the selected lanes.

Test Plan:
- Reset then WAIT_CYCLES=0: write 0xDEADBEEF to addr 0x010 (wstrb=0xF), read 0x010 next cycle -> rvalid exactly one cycle after read acceptance, rdata=0xDEADBEEF, ready constantly 1.
- Byte lanes: write 0x11223344 to 0x020, then write 0xAABBCCDD with wstrb=0x5, then read -> rdata=0x11BB33DD. Address 0x023 aliases to the same word.
- WAIT_CYCLES=3: read accepted at edge T -> ready low for T+1..T+3 and high at T+4. rvalid high only at T+4. A request held during T+1..T+3 is accepted at T+4, not before.
- Reset mid-WAIT (WAIT_CYCLES=3): write 0x0 to 0x040 first, then write 0xFFFFFFFF to 0x040. Assert rst_n_i=0 at T+1 -> no commit, so a later read of 0x040 returns 0x0. ready=1 and rvalid=0 after reset.
- cke_i stall: WAIT_CYCLES=2, drop cke_i for 5 cycles during WAIT -> completion delayed by exactly 5 cycles, single rvalid pulse, correct data.
- Throughput: WAIT_CYCLES=0, 16 back-to-back reads with avalid held high -> 16 rvalid pulses on consecutive cycles, data in request order.
